// File: rtl/im_boot_loader.sv
// im_boot_loader
//   Boot-time instruction-memory loader. Receives a byte stream over a
//   valid/ready handshake, packs each group of 4 bytes little-endian into a
//   32-bit word and writes the words to instruction memory at consecutive
//   word addresses starting from 0. The rv32i core is held in reset
//   (cpu_reset=1) until the requested number of words has been written.
//
// Ports
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   start        load request, honoured only in IDLE and DONE
//   n_words      word count captured on an accepted start (0 or >DEPTH => DEPTH)
//   byte_valid   stream byte valid
//   byte_data    stream byte (first byte of a word lands in bits [7:0])
//   byte_ready   loader accepts a byte this cycle
//   im_we        instruction-memory write strobe, one cycle per word
//   im_addr      instruction-memory word address
//   im_wd        instruction-memory write data
//   cpu_reset    core reset, high while the program is not loaded
//   busy         loader receiving or writing
//   done         program loaded, core released
module im_boot_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   n_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] last_idx;   // clamped count minus one
  logic [ADDR_W-1:0] last_cap;
  logic [23:0]       asm_q;      // lower three lanes of the word being assembled
  logic              start_ok;
  logic              xfer;
  logic              last_word;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign xfer      = (state == S_RECV) && byte_valid;
  assign last_word = (word_cnt == last_idx);

  // A count of 0 or anything with the top bit set (>= DEPTH) maps to the
  // full memory, whose last index is all ones.
  always_comb begin
    if (n_words[ADDR_W] || (n_words == '0)) begin
      last_cap = '1;
    end else begin
      last_cap = n_words[ADDR_W-1:0] - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_RECV;
      S_RECV:  if (xfer && (byte_cnt == 2'd3)) state_nx = S_WRITE;
      S_WRITE: state_nx = last_word ? S_DONE : S_RECV;
      S_DONE:  if (start_ok) state_nx = S_RECV;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      last_idx <= '0;
      asm_q    <= '0;
      im_addr  <= '0;
      im_wd    <= '0;
    end else begin
      if (start_ok) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        last_idx <= last_cap;
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: asm_q[7:0]   <= byte_data;
          2'd1: asm_q[15:8]  <= byte_data;
          2'd2: asm_q[23:16] <= byte_data;
          default: begin
            // The fourth byte goes straight into the output register so the
            // complete word is already registered during the WRITE cycle.
            im_addr <= word_cnt;
            im_wd   <= {byte_data, asm_q};
          end
        endcase
      end
      if ((state == S_WRITE) && !last_word) begin
        word_cnt <= word_cnt + ADDR_W'(1);
      end
    end
  end

  assign byte_ready = (state == S_RECV);
  assign im_we      = (state == S_WRITE);
  assign busy       = (state == S_RECV) || (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign cpu_reset  = (state != S_DONE);

endmodule
